// File: rtl/pa_cal_stats.sv
`default_nettype none
// pa_cal_stats: reads a RAM address range, accumulates sum/min/max and divides for the mean.
// Revision 1.0
module pa_cal_stats #(
  parameter int SIZE_ADDR = 32,
  parameter int SIZE_DATA = 32,
  parameter bit SIGNED    = 1'b0,
  parameter int ACC_W     = SIZE_DATA + SIZE_ADDR
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_round,
  input  logic [SIZE_ADDR-1:0] i_addr_si,
  input  logic [SIZE_ADDR-1:0] i_addr_ei,
  output logic                 o_en_ram,
  output logic [SIZE_ADDR-1:0] o_addr_ram,
  input  logic [SIZE_DATA-1:0] i_data_ram,
  input  logic                 i_valid_ram,
  output logic [SIZE_DATA-1:0] o_mean_value,
  output logic [SIZE_DATA-1:0] o_min_value,
  output logic [SIZE_DATA-1:0] o_max_value,
  output logic [SIZE_ADDR-1:0] o_count,
  output logic                 o_busy,
  output logic                 o_error,
  output logic                 o_done
);
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [SIZE_DATA-1:0] MIN_INIT =
    SIGNED ? {1'b0, {(SIZE_DATA-1){1'b1}}} : {SIZE_DATA{1'b1}};
  localparam logic [SIZE_DATA-1:0] MAX_INIT =
    SIGNED ? {1'b1, {(SIZE_DATA-1){1'b0}}} : {SIZE_DATA{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [SIZE_ADDR-1:0] addr, addr_ei, count, count_nx, half_cnt;
  logic                 round_mode, err, neg, neg_nx, last;
  logic [ACC_W-1:0]     acc, acc_nx, ext, mag, dividend;
  logic [SIZE_DATA-1:0] min_v, max_v, mean_q;
  logic                 lt_min, gt_max;
  logic [ACC_W-1:0]     quo, quo_nx;
  logic [SIZE_ADDR-1:0] rem, rem_nx;
  logic [SIZE_ADDR:0]   rem_sh;
  logic                 ge;
  logic [CNT_W-1:0]     div_cnt;

  assign o_addr_ram = addr;

  always_comb begin
    if (SIGNED) begin
      ext    = {{(ACC_W-SIZE_DATA){i_data_ram[SIZE_DATA-1]}}, i_data_ram};
      lt_min = $signed(i_data_ram) < $signed(min_v);
      gt_max = $signed(i_data_ram) > $signed(max_v);
    end else begin
      ext    = {{(ACC_W-SIZE_DATA){1'b0}}, i_data_ram};
      lt_min = i_data_ram < min_v;
      gt_max = i_data_ram > max_v;
    end
    acc_nx   = acc + ext;
    count_nx = count + SIZE_ADDR'(1);
    last     = (addr == addr_ei);
    // Divide the magnitude so truncation and rounding are symmetric about zero.
    neg_nx   = SIGNED && acc_nx[ACC_W-1];
    mag      = neg_nx ? (~acc_nx + ACC_W'(1)) : acc_nx;
    half_cnt = round_mode ? (count_nx >> 1) : '0;
    dividend = mag + {{(ACC_W-SIZE_ADDR){1'b0}}, half_cnt};
    rem_sh   = {rem, quo[ACC_W-1]};
    ge       = rem_sh >= {1'b0, count};
    rem_nx   = ge ? SIZE_ADDR'(rem_sh - {1'b0, count}) : rem_sh[SIZE_ADDR-1:0];
    quo_nx   = {quo[ACC_W-2:0], ge};
    mean_q   = neg ? (~quo[SIZE_DATA-1:0] + SIZE_DATA'(1)) : quo[SIZE_DATA-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_en_ram = 1'b0;
    case (state)
      S_IDLE: if (i_start) state_nx = (i_addr_ei < i_addr_si) ? S_DONE : S_REQ;
      S_REQ: begin
        o_en_ram = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (i_valid_ram) begin
          if (!last)                state_nx = S_REQ;
          else if (count_nx == '0)  state_nx = S_DONE;
          else                      state_nx = S_DIV;
        end
      end
      S_DIV:  if (div_cnt == '0) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr <= '0; addr_ei <= '0; count <= '0; round_mode <= 1'b0;
      err <= 1'b0; neg <= 1'b0; acc <= '0; min_v <= '0; max_v <= '0;
      quo <= '0; rem <= '0; div_cnt <= '0;
      o_mean_value <= '0; o_min_value <= '0; o_max_value <= '0; o_count <= '0;
      o_busy <= 1'b0; o_error <= 1'b0; o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            addr       <= i_addr_si;
            addr_ei    <= i_addr_ei;
            round_mode <= i_round;
            err        <= (i_addr_ei < i_addr_si);
            acc        <= '0;
            count      <= '0;
            min_v      <= MIN_INIT;
            max_v      <= MAX_INIT;
            o_busy     <= 1'b1;
            o_error    <= 1'b0;
            o_mean_value <= '0; o_min_value <= '0; o_max_value <= '0; o_count <= '0;
          end
        end
        S_WAIT: begin
          if (i_valid_ram) begin
            acc   <= acc_nx;
            count <= count_nx;
            if (lt_min) min_v <= i_data_ram;
            if (gt_max) max_v <= i_data_ram;
            if (last) begin
              quo     <= dividend;
              rem     <= '0;
              div_cnt <= CNT_W'(ACC_W - 1);
              neg     <= neg_nx;
              // A full address-space range wraps the count to zero.
              err     <= (count_nx == '0);
            end else begin
              addr <= addr + SIZE_ADDR'(1);
            end
          end
        end
        S_DIV: begin
          quo     <= quo_nx;
          rem     <= rem_nx;
          div_cnt <= div_cnt - CNT_W'(1);
        end
        S_DONE: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          o_error <= err;
          if (!err) begin
            o_mean_value <= mean_q;
            o_min_value  <= min_v;
            o_max_value  <= max_v;
            o_count      <= count;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pa_cal_stats.sv
`default_nettype none
// tb_pa_cal_stats: directed runs on unsigned and signed instances checked against a bench model.
module tb_pa_cal_stats;
  localparam int AW = 4, DW = 8, ACC_W = AW + DW;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rnd = 1'b0, valid_ram = 1'b0;
  logic [AW-1:0] addr_si = '0, addr_ei = '0;
  logic [DW-1:0] data_ram = '0;
  logic en_u, en_s, busy_u, busy_s, err_u, err_s, done_u, done_s;
  logic [AW-1:0] addr_u, addr_s, cnt_u, cnt_s;
  logic [DW-1:0] mean_u, min_u, max_u, mean_s, min_s, max_s;
  logic [DW-1:0] ram [16];

  int cyc = 0, errors = 0, checks = 0;
  int st = 0, exp_d = 0, exp_nreq = 0, nreq = 0, t_si = 0, lat = 1, done_lat = 0;
  bit active = 1'b0, got_done = 1'b0;
  logic [DW-1:0] e_mean_u, e_min_u, e_max_u, e_mean_s, e_min_s, e_max_s;
  logic [AW-1:0] e_cnt;
  logic          e_err;
  bit pend = 1'b0;
  int due = 0;
  logic [AW-1:0] paddr = '0;

  always #5 clk = ~clk;

  pa_cal_stats #(.SIZE_ADDR(AW), .SIZE_DATA(DW), .SIGNED(1'b0), .ACC_W(ACC_W)) dut_u (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_round(rnd),
    .i_addr_si(addr_si), .i_addr_ei(addr_ei), .o_en_ram(en_u), .o_addr_ram(addr_u),
    .i_data_ram(data_ram), .i_valid_ram(valid_ram), .o_mean_value(mean_u),
    .o_min_value(min_u), .o_max_value(max_u), .o_count(cnt_u), .o_busy(busy_u),
    .o_error(err_u), .o_done(done_u));

  pa_cal_stats #(.SIZE_ADDR(AW), .SIZE_DATA(DW), .SIGNED(1'b1), .ACC_W(ACC_W)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_round(rnd),
    .i_addr_si(addr_si), .i_addr_ei(addr_ei), .o_en_ram(en_s), .o_addr_ram(addr_s),
    .i_data_ram(data_ram), .i_valid_ram(valid_ram), .o_mean_value(mean_s),
    .o_min_value(min_s), .o_max_value(max_s), .o_count(cnt_s), .o_busy(busy_s),
    .o_error(err_s), .o_done(done_s));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mean_of(input longint s, input int n, input bit r);
    longint m;
    m = (s < 0) ? -s : s;
    if (r) m += n / 2;
    m = m / n;
    if (s < 0) m = -m;
    return m[DW-1:0];
  endfunction

  // Expected results straight from the arithmetic definition of the statistics.
  task automatic model(input int si, input int ei, input bit r, input int l);
    int n, v, mnu, mxu, mns, mxs;
    longint su, ss;
    exp_nreq = (ei < si) ? 0 : ei - si + 1;
    n        = exp_nreq % 16;
    exp_d    = (ei < si) ? 2 : (n == 0) ? -1 : 1 + n * (1 + l) + ACC_W + 1;
    su = 0; ss = 0; mnu = 255; mxu = 0; mns = 127; mxs = -128;
    for (int i = si; i <= ei; i++) begin
      su += ram[i];
      v = $signed(ram[i]);
      ss += v;
      if (ram[i] < mnu) mnu = ram[i];
      if (ram[i] > mxu) mxu = ram[i];
      if (v < mns) mns = v;
      if (v > mxs) mxs = v;
    end
    e_err = (n == 0);
    if (e_err) begin
      e_mean_u = '0; e_min_u = '0; e_max_u = '0; e_mean_s = '0; e_min_s = '0; e_max_s = '0;
      e_cnt = '0;
    end else begin
      e_mean_u = mean_of(su, n, r); e_min_u = DW'(mnu); e_max_u = DW'(mxu);
      e_mean_s = mean_of(ss, n, r); e_min_s = DW'(mns); e_max_s = DW'(mxs);
      e_cnt = AW'(n);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM responder: one answer per request, lat cycles later; deliberately not reset.
  initial forever begin
    @(negedge clk);
    valid_ram = 1'b0;
    if (pend && cyc == due) begin
      valid_ram = 1'b1;
      data_ram  = ram[paddr];
      pend      = 1'b0;
    end
    if (en_u) begin
      pend  = 1'b1;
      due   = cyc + lat;
      paddr = addr_u;
    end
  end

  initial forever begin
    @(negedge clk);
    if (active) begin
      chk("en_match", en_s, en_u);
      if (exp_d > 0) begin
        chk("done_time", done_u, cyc == st + exp_d);
        chk("busy", busy_u, (cyc > st) && (cyc < st + exp_d));
      end
      if (cyc == st + 1) begin
        chk("clr_mean", mean_u, 0);
        chk("clr_cnt", cnt_u, 0);
        chk("clr_min_s", min_s, 0);
        chk("clr_err", err_u, 0);
      end
      if (en_u) begin
        chk("req_addr", addr_u, (t_si + nreq) % 16);
        nreq++;
      end
      if (done_u && !got_done) begin
        got_done = 1'b1;
        done_lat = cyc - st;
        chk("done_s", done_s, 1);
        chk("nreq", nreq, exp_nreq);
        chk("mean_u", mean_u, e_mean_u);
        chk("min_u", min_u, e_min_u);
        chk("max_u", max_u, e_max_u);
        chk("cnt_u", cnt_u, e_cnt);
        chk("err_u", err_u, e_err);
        chk("mean_s", mean_s, e_mean_s);
        chk("min_s", min_s, e_min_s);
        chk("max_s", max_s, e_max_s);
        chk("cnt_s", cnt_s, e_cnt);
        chk("err_s", err_s, e_err);
      end
    end
  end

  task automatic run(input int si, input int ei, input bit r, input int l, input bit poke);
    model(si, ei, r, l);
    @(negedge clk);
    lat = l; t_si = si; nreq = 0; got_done = 1'b0;
    addr_si = AW'(si); addr_ei = AW'(ei); rnd = r; start = 1'b1;
    st = cyc; active = 1'b1;
    @(negedge clk);
    start = 1'b0; rnd = ~r; addr_si = ~AW'(si); addr_ei = ~AW'(ei);
    for (int i = 0; i < 300 && !got_done; i++) begin
      if (poke) start = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    chk("timeout", got_done, 1);
    repeat (2) @(negedge clk);
    active = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = DW'(i * 7 + 3);
    ram[0] = 8'd10; ram[1] = 8'd20; ram[2] = 8'd30; ram[3] = 8'd41;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_u, 0); chk("rst_done", done_u, 0); chk("rst_en", en_u, 0);
    chk("rst_mean", mean_u, 0); chk("rst_min", min_u, 0); chk("rst_max", max_u, 0);
    chk("rst_cnt", cnt_u, 0); chk("rst_err", err_u, 0); chk("rst_busy_s", busy_s, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 3, 1'b0, 1, 1'b0);
    chk("lit_mean_t", mean_u, 25); chk("lit_min", min_u, 10);
    chk("lit_max", max_u, 41); chk("lit_cnt", cnt_u, 4); chk("lit_nreq", nreq, 4);
    run(0, 3, 1'b1, 2, 1'b0);
    chk("lit_mean_r", mean_u, 25);
    ram[3] = 8'd42;
    run(0, 3, 1'b1, 1, 1'b0);
    chk("lit_mean_r2", mean_u, 26);

    ram[8] = 8'hFD; ram[9] = 8'hFC;
    run(8, 9, 1'b0, 1, 1'b0);
    chk("lit_smean_t", mean_s, 8'hFD); chk("lit_smin", min_s, 8'hFC); chk("lit_smax", max_s, 8'hFD);
    run(8, 9, 1'b1, 1, 1'b0);
    chk("lit_smean_r", mean_s, 8'hFC);

    ram[5] = 8'h7F;
    run(5, 5, 1'b0, 7, 1'b0);
    chk("lit_single_mean", mean_u, 8'h7F); chk("lit_single_cnt", cnt_u, 1);
    chk("lit_single_lat", done_lat, 1 + 8 + ACC_W + 1);

    run(6, 2, 1'b0, 1, 1'b0);
    chk("lit_rng_err", err_u, 1); chk("lit_rng_lat", done_lat, 2); chk("lit_rng_nreq", nreq, 0);

    ram[10] = 8'h80; ram[11] = 8'h7F; ram[12] = 8'h01;
    run(10, 12, 1'b1, 1, 1'b1);
    chk("lit_mix_mean_u", mean_u, 85); chk("lit_mix_mean_s", mean_s, 0);

    run(0, 15, 1'b0, 1, 1'b0);
    chk("lit_wrap_err", err_u, 1); chk("lit_wrap_nreq", nreq, 16);

    // Reset while waiting for RAM data; the late response must be ignored.
    @(negedge clk);
    lat = 6; addr_si = '0; addr_ei = 4'd3; start = 1'b1; st = cyc;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy_u, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy_u, 0); chk("mid_rst_busy_s", busy_s, 0);
    chk("mid_rst_en", en_u, 0); chk("mid_rst_done", done_u, 0);
    chk("mid_rst_cnt", cnt_u, 0); chk("mid_rst_err", err_u, 0);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("stray_en", en_u, 0);
      chk("stray_busy", busy_u, 0);
      chk("stray_done", done_u, 0);
    end
    chk("stray_mean", mean_u, 0);

    run(0, 3, 1'b0, 1, 1'b0);
    chk("lit_after_rst", mean_u, 25); chk("lit_after_rst_max", max_u, 42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
